spi_framebuffer_writer: RTL

Receives the host's pixel stream on the two-wire SPI link (`spi_sck`/`spi_sda`, no chip-select) and turns it into sequential byte writes to the frame-buffer SRAM. It sits directly upstream of the ILI9341 scan-out logic: it produces the `spi_ready` flow-control signal and the SRAM write traffic that the display path later reads back. A small byte FIFO decouples serial arrival from SRAM write grants. An idle timeout provides frame/byte resynchronisation in the absence of a chip-select.

---
 rtl/ili9341_pkg.sv | 22 ++
 rtl/byte_fifo.sv | 64 ++++++
 rtl/spi_framebuffer_writer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ili9341_pkg.sv
// Shared definitions for the ILI9341 frame-buffer write and scan-out paths.
package ili9341_pkg;

    // Frame-buffer write FSM encoding.
    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_REQ  = 1'b1
    } wr_state_e;

    // 240 x 240 pixels at one byte each.
    localparam int unsigned FRAME_BYTES_DEFAULT = 57600;

    // Next frame-buffer address, wrapping after the last byte of a frame.
    function automatic logic [31:0] next_frame_addr(input logic [31:0] addr,
                                                    input logic [31:0] frame_bytes);
        if (addr == frame_bytes - 32'd1) begin
            return 32'd0;
        end
        return addr + 32'd1;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with a registered occupancy count.
module byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is dropped; the caller flags it.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem[rd_ptr_q];

    // Storage array; contents are don't-care until pointed at, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers and count; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_framebuffer_writer.sv
// Two-wire SPI receiver feeding sequential byte writes into the frame-buffer SRAM.
module spi_framebuffer_writer
    import ili9341_pkg::*;
#(
    parameter int unsigned CLOCKS_IDLE_TIMEOUT = 1200,
    parameter int unsigned FRAME_BYTES         = FRAME_BYTES_DEFAULT,
    parameter int unsigned ADDR_WIDTH          = 16,
    parameter int unsigned FIFO_DEPTH          = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_sck,
    input  logic                  spi_sda,
    output logic                  spi_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  wr_req,
    input  logic                  wr_ack,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TMR_W = $clog2(CLOCKS_IDLE_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_BYTES - 1);

    // Synchroniser and edge-detect state
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic sda_meta_q, sda_sync_q;
    logic sck_rise;

    // Shifter state
    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       push_q;
    logic [7:0] push_byte_q;

    // Idle timer
    logic [TMR_W-1:0] idle_cnt_q;
    logic             idle_hit;

    // FIFO interface
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_pop;

    // Write FSM
    wr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic                  resync_q, resync_d;

    logic spi_ready_q;
    logic overflow_q;

    // Two-stage synchronisers plus the previous-sck register for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            sda_meta_q <= 1'b0;
            sda_sync_q <= 1'b0;
        end else begin
            sck_meta_q <= spi_sck;
            sck_sync_q <= sck_meta_q;
            sck_prev_q <= sck_sync_q;
            sda_meta_q <= spi_sda;
            sda_sync_q <= sda_meta_q;
        end
    end

    assign sck_rise = sck_sync_q && !sck_prev_q;

    // Saturating idle timer; fires once on the cycle it reaches the timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_q <= '0;
        end else if (sck_rise) begin
            idle_cnt_q <= '0;
        end else if (idle_cnt_q != TMR_W'(CLOCKS_IDLE_TIMEOUT)) begin
            idle_cnt_q <= idle_cnt_q + TMR_W'(1);
        end
    end

    assign idle_hit = !sck_rise && (idle_cnt_q == TMR_W'(CLOCKS_IDLE_TIMEOUT - 1));

    // MSB-first shifter; a completed byte is staged one cycle before the FIFO push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            push_q      <= 1'b0;
            push_byte_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (sck_rise) begin
                shift_q <= {shift_q[5:0], sda_sync_q};
                if (bit_cnt_q == 3'd7) begin
                    push_q      <= 1'b1;
                    push_byte_q <= {shift_q, sda_sync_q};
                    bit_cnt_q   <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
            end else if (idle_hit) begin
                // Without a chip-select, a long gap means any partial byte is stale.
                bit_cnt_q <= '0;
            end
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_q),
        .push_data (push_byte_q),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Flow control and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spi_ready_q <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            // One entry of slack absorbs the host's reaction latency.
            spi_ready_q <= (fifo_count <= CNT_W'(FIFO_DEPTH - 2));
            if (push_q && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Write FSM state and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= W_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            resync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            resync_q <= resync_d;
        end
    end

    // Write FSM next-state, FIFO pop and frame-done pulse.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        resync_d   = resync_q;
        fifo_pop   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            W_IDLE: begin
                // Resync waits for queued bytes to drain so they keep their addresses.
                if (resync_q && fifo_empty) begin
                    addr_d   = '0;
                    resync_d = 1'b0;
                end else if (!fifo_empty) begin
                    data_d  = fifo_head;
                    state_d = W_REQ;
                end
            end
            W_REQ: begin
                if (wr_ack) begin
                    fifo_pop = 1'b1;
                    state_d  = W_IDLE;
                    addr_d   = ADDR_WIDTH'(next_frame_addr(32'(addr_q), 32'(FRAME_BYTES)));
                    if (addr_q == LAST_ADDR) begin
                        frame_done = 1'b1;
                    end
                end
            end
            default: state_d = W_IDLE;
        endcase
        if (idle_hit && (addr_q != '0)) begin
            resync_d = 1'b1;
        end
    end

    assign wr_req    = (state_q == W_REQ);
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign spi_ready = spi_ready_q;
    assign overflow  = overflow_q;

endmodule
